// File: rtl/flash_loader_pkg.sv
// Shared types and helpers for the UART-driven program-memory loader.
package flash_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    LEN,
    DATA,
    CSUM,
    DONE,
    ERROR
  } flash_state_t;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } flash_err_t;

  localparam int unsigned BYTES_PER_WORD = 4;

  function automatic logic [31:0] word_addr(input logic [15:0] idx);
    return {14'b0, idx, 2'b00};
  endfunction

endpackage

// File: rtl/flash_loader_byte_word_assembler.sv
// Four-byte MSB-first shifter; word_done flags the byte that completes a word.
module byte_word_assembler
  import flash_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_in,
  output logic [31:0] word_next,
  output logic        word_done
);

  logic [31:0] shift_q, shift_d;
  logic [1:0]  cnt_q, cnt_d;

  always_comb begin
    word_next = {shift_q[23:0], byte_in};
    word_done = byte_valid && (cnt_q == 2'(BYTES_PER_WORD - 1));
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    if (clr) begin
      shift_d = '0;
      cnt_d   = '0;
    end else if (byte_valid) begin
      shift_d = word_next;
      cnt_d   = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/flash_loader.sv
// In-system program loader: clear, length header, MSB-first words, XOR checksum.
module flash_loader
  import flash_loader_pkg::*;
#(
  parameter int unsigned MEM_WORDS      = 1024,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flash_req,
  input  logic [7:0]  uart_data,
  input  logic        uart_received,
  output logic        mem_clear,
  output logic        mem_write_enable,
  output logic [31:0] mem_write_address,
  output logic [31:0] mem_write_data,
  output logic        core_hold,
  output logic        load_done,
  output logic        load_error,
  output logic [1:0]  error_code,
  output logic [15:0] words_loaded
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  flash_state_t     state_q, state_d;
  flash_err_t       err_q, err_d;
  logic             req_prev_q;
  logic [31:0]      len_q, len_d;
  logic [15:0]      idx_q, idx_d;
  logic [15:0]      wl_q, wl_d;
  logic [7:0]       csum_q, csum_d;
  logic [TW-1:0]    tmo_q, tmo_d;
  logic             clear_q, clear_d;
  logic             wen_q, wen_d;
  logic [31:0]      waddr_q, waddr_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             hold_q, hold_d;
  logic             done_q, done_d;
  logic             fail_q, fail_d;

  logic             req_rise;
  logic             in_rx;
  logic             tmo_hit;
  logic             asm_clr;
  logic             asm_valid;
  logic [31:0]      asm_word;
  logic             asm_done;

  assign req_rise  = flash_req && !req_prev_q;
  assign in_rx     = (state_q == LEN) || (state_q == DATA) || (state_q == CSUM);
  assign tmo_hit   = (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign asm_clr   = (state_q == IDLE);
  // A byte landing in the single CLEAR cycle is the first header byte, not noise.
  assign asm_valid = uart_received && flash_req &&
                     ((state_q == CLEAR) || (state_q == LEN) || (state_q == DATA));

  byte_word_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr        (asm_clr),
    .byte_valid (asm_valid),
    .byte_in    (uart_data),
    .word_next  (asm_word),
    .word_done  (asm_done)
  );

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    len_d   = len_q;
    idx_d   = idx_q;
    wl_d    = wl_q;
    csum_d  = csum_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;

    unique case (state_q)
      IDLE: begin
        if (req_rise) begin
          state_d = CLEAR;
          err_d   = ERR_NONE;
          len_d   = '0;
          idx_d   = '0;
          wl_d    = '0;
          csum_d  = '0;
        end
      end
      CLEAR: begin
        state_d = flash_req ? LEN : IDLE;
      end
      LEN: begin
        if (!flash_req) begin
          state_d = IDLE;
        end else if (asm_done) begin
          len_d = asm_word;
          if (asm_word > MEM_WORDS) begin
            state_d = ERROR;
            err_d   = ERR_LEN;
          end else if (asm_word == '0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end else if (!uart_received && tmo_hit) begin
          state_d = ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      DATA: begin
        if (!flash_req) begin
          state_d = IDLE;
        end else if (uart_received) begin
          csum_d = csum_q ^ uart_data;
          if (asm_done) begin
            wen_d   = 1'b1;
            wdata_d = asm_word;
            waddr_d = word_addr(idx_q);
            idx_d   = idx_q + 16'd1;
            wl_d    = wl_q + 16'd1;
            if ({16'd0, idx_q + 16'd1} == len_q) begin
              state_d = CSUM;
            end
          end
        end else if (tmo_hit) begin
          state_d = ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      CSUM: begin
        if (!flash_req) begin
          state_d = IDLE;
        end else if (uart_received) begin
          if (uart_data == csum_q) begin
            state_d = DONE;
          end else begin
            state_d = ERROR;
            err_d   = ERR_CSUM;
          end
        end else if (tmo_hit) begin
          state_d = ERROR;
          err_d   = ERR_TIMEOUT;
        end
      end
      DONE, ERROR: begin
        if (!flash_req) begin
          state_d = IDLE;
          err_d   = ERR_NONE;
        end
      end
      default: begin
        state_d = IDLE;
        err_d   = ERR_NONE;
      end
    endcase
  end

  always_comb begin
    tmo_d = '0;
    if (in_rx && (state_d == state_q) && !uart_received) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_comb begin
    clear_d = (state_d == CLEAR);
    hold_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    fail_d  = (state_d == ERROR);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      err_q      <= ERR_NONE;
      req_prev_q <= 1'b0;
      len_q      <= '0;
      idx_q      <= '0;
      wl_q       <= '0;
      csum_q     <= '0;
      tmo_q      <= '0;
      clear_q    <= 1'b0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      hold_q     <= 1'b0;
      done_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      req_prev_q <= flash_req;
      len_q      <= len_d;
      idx_q      <= idx_d;
      wl_q       <= wl_d;
      csum_q     <= csum_d;
      tmo_q      <= tmo_d;
      clear_q    <= clear_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      fail_q     <= fail_d;
    end
  end

  assign mem_clear         = clear_q;
  assign mem_write_enable  = wen_q;
  assign mem_write_address = waddr_q;
  assign mem_write_data    = wdata_q;
  assign core_hold         = hold_q;
  assign load_done         = done_q;
  assign load_error        = fail_q;
  assign error_code        = err_q;
  assign words_loaded      = wl_q;

endmodule

// File: tb/tb_flash_loader.sv
// Scoreboard bench: stimulus pushes expected clear/write/status events, a monitor pops them.
module tb_flash_loader;

  localparam int EV_CLEAR = 0;
  localparam int EV_WRITE = 1;
  localparam int EV_DONE  = 2;
  localparam int EV_ERROR = 3;

  typedef struct {
    int          kind;
    logic [31:0] a;
    logic [31:0] b;
  } evt_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        flash_req;
  logic [7:0]  uart_data;
  logic        uart_received;
  logic        mem_clear;
  logic        mem_write_enable;
  logic [31:0] mem_write_address;
  logic [31:0] mem_write_data;
  logic        core_hold;
  logic        load_done;
  logic        load_error;
  logic [1:0]  error_code;
  logic [15:0] words_loaded;

  int   checks = 0;
  int   errors = 0;
  evt_t sb[$];
  logic done_prev = 1'b0;
  logic err_prev  = 1'b0;

  flash_loader #(
    .MEM_WORDS      (1024),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .flash_req         (flash_req),
    .uart_data         (uart_data),
    .uart_received     (uart_received),
    .mem_clear         (mem_clear),
    .mem_write_enable  (mem_write_enable),
    .mem_write_address (mem_write_address),
    .mem_write_data    (mem_write_data),
    .core_hold         (core_hold),
    .load_done         (load_done),
    .load_error        (load_error),
    .error_code        (error_code),
    .words_loaded      (words_loaded)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h expected=0x%08h", name, got, exp);
    end
  endtask

  task automatic expect_evt(input int kind, input logic [31:0] a, input logic [31:0] b);
    evt_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event got kind=%0d a=0x%08h b=0x%08h expected none", kind, a, b);
    end else begin
      e = sb.pop_front();
      if (e.kind != kind || e.a !== a || e.b !== b) begin
        errors++;
        $display("FAIL event got kind=%0d a=0x%08h b=0x%08h expected kind=%0d a=0x%08h b=0x%08h",
                 kind, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // Monitor: every visible output event must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (mem_clear) expect_evt(EV_CLEAR, 32'd0, 32'd0);
      if (mem_write_enable) expect_evt(EV_WRITE, mem_write_address, mem_write_data);
      if (load_done && !done_prev) expect_evt(EV_DONE, {30'd0, error_code}, {16'd0, words_loaded});
      if (load_error && !err_prev) expect_evt(EV_ERROR, {30'd0, error_code}, {16'd0, words_loaded});
    end
    done_prev = load_done;
    err_prev  = load_error;
  end

  task automatic push(input int kind, input logic [31:0] a, input logic [31:0] b);
    evt_t e;
    e.kind = kind;
    e.a    = a;
    e.b    = b;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_data     = b;
    uart_received = 1'b1;
    @(posedge clk);
    #1;
    uart_received = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    logic [31:0] t;
    t = w;
    for (int i = 3; i >= 0; i--) send_byte(t[i*8 +: 8]);
  endtask

  task automatic start_load();
    flash_req = 1'b1;
    push(EV_CLEAR, 32'd0, 32'd0);
    idle(2);
  endtask

  task automatic wait_status();
    int n;
    n = 0;
    while (!(load_done || load_error) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL status_wait got=no_status expected=done_or_error");
    end
  endtask

  task automatic end_load(input string tag);
    @(negedge clk);
    check({tag, "_hold_in_status"}, {31'd0, core_hold}, 32'd1);
    @(posedge clk);
    #1;
    flash_req = 1'b0;
    idle(2);
    @(negedge clk);
    check({tag, "_hold_released"}, {31'd0, core_hold}, 32'd0);
    check({tag, "_flags_cleared"}, {28'd0, load_done, load_error, error_code}, 32'd0);
    check({tag, "_sb_drained"}, sb.size(), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Checksum over 50 00 93 00 A0 01 13 (plus zero bytes) is 0x71.
  task automatic run_normal(input string tag, input logic [7:0] csum, input logic ok);
    start_load();
    send_word(32'd2);
    @(negedge clk);
    check({tag, "_hold_mid_load"}, {31'd0, core_hold}, 32'd1);
    @(posedge clk);
    #1;
    push(EV_WRITE, 32'h0, 32'h00500093);
    push(EV_WRITE, 32'h4, 32'h00A00113);
    if (ok) push(EV_DONE, 32'd0, 32'd2);
    else    push(EV_ERROR, 32'd1, 32'd2);
    send_word(32'h00500093);
    send_word(32'h00A00113);
    send_byte(csum);
    wait_status();
    check({tag, "_words_loaded"}, {16'd0, words_loaded}, 32'd2);
    end_load(tag);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst           = 1'b1;
    flash_req     = 1'b0;
    uart_data     = 8'h00;
    uart_received = 1'b0;
    idle(3);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ctrl", {26'd0, mem_clear, mem_write_enable, core_hold, load_done, load_error, 1'b0},
          32'd0);
    check("reset_code_words", {14'd0, error_code, words_loaded}, 32'd0);
    check("reset_addr", mem_write_address, 32'd0);
    check("reset_data", mem_write_data, 32'd0);
    @(posedge clk);
    #1;

    run_normal("normal", 8'h71, 1'b1);

    // Zero-length image: only the checksum byte follows.
    start_load();
    push(EV_DONE, 32'd0, 32'd0);
    send_word(32'd0);
    send_byte(8'h00);
    wait_status();
    end_load("zero_len");

    run_normal("csum_bad", 8'h78, 1'b0);
    check("csum_bad_code_cleared", {30'd0, error_code}, 32'd0);

    // One word over depth is rejected before any data.
    start_load();
    push(EV_ERROR, 32'd2, 32'd0);
    send_word(32'h00000401);
    wait_status();
    end_load("len_over");

    // Exactly MEM_WORDS is accepted; abort after two words.
    start_load();
    push(EV_WRITE, 32'h0, 32'h11111111);
    push(EV_WRITE, 32'h4, 32'h22222222);
    send_word(32'h00000400);
    send_word(32'h11111111);
    send_word(32'h22222222);
    idle(1);
    flash_req = 1'b0;
    idle(2);
    @(negedge clk);
    check("len_max_no_error", {30'd0, load_done, load_error}, 32'd0);
    check("len_max_words", {16'd0, words_loaded}, 32'd2);
    check("len_max_idle", {31'd0, core_hold}, 32'd0);
    check("len_max_sb_drained", sb.size(), 32'd0);
    @(posedge clk);
    #1;

    // Timeout: five data bytes then silence for 100 cycles.
    start_load();
    push(EV_WRITE, 32'h0, 32'h11223344);
    push(EV_ERROR, 32'd3, 32'd1);
    send_word(32'd2);
    send_word(32'h11223344);
    send_byte(8'h55);
    idle(99);
    @(negedge clk);
    check("timeout_not_early", {31'd0, load_error}, 32'd0);
    idle(1);
    @(negedge clk);
    check("timeout_fires", {31'd0, load_error}, 32'd1);
    check("timeout_code", {30'd0, error_code}, 32'd3);
    check("timeout_words", {16'd0, words_loaded}, 32'd1);
    end_load("timeout");

    // Back-to-back bytes, writes overlap the next word's first byte; csum 0x16.
    start_load();
    push(EV_WRITE, 32'h0, 32'hDEADBEEF);
    push(EV_WRITE, 32'h4, 32'h01020304);
    push(EV_WRITE, 32'h8, 32'hCAFEBABE);
    push(EV_DONE, 32'd0, 32'd3);
    send_word(32'd3);
    send_word(32'hDEADBEEF);
    send_word(32'h01020304);
    send_word(32'hCAFEBABE);
    send_byte(8'h16);
    wait_status();
    end_load("b2b");

    // Asynchronous reset in the middle of DATA.
    start_load();
    push(EV_WRITE, 32'h0, 32'hA1B2C3D4);
    send_word(32'd3);
    send_word(32'hA1B2C3D4);
    send_byte(8'h55);
    send_byte(8'h66);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_ctrl", {27'd0, mem_clear, mem_write_enable, core_hold, load_done, load_error},
          32'd0);
    check("rst_async_words", {14'd0, error_code, words_loaded}, 32'd0);
    check("rst_async_bus", mem_write_address | mem_write_data, 32'd0);
    check("rst_sb_drained", sb.size(), 32'd0);
    flash_req = 1'b0;
    idle(2);
    rst = 1'b0;
    idle(2);

    run_normal("restart", 8'h71, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
